// File: rtl/grf_wb_arbiter_if.sv
// grf_wb_arbiter_if: writeback-source requests, register-file write port, hazard query and write counter
//   v0..v2/a0..a2/d0..d2/p0..p2 : per-source request valid, dest reg, data, pc
//   rdy0..rdy2                  : per-source grant
//   stall                       : freezes arbitration
//   WE/A3/WD/pc                 : registered register-file write port and trace pc
//   ra1/ra2, pend1/pend2        : read addresses and their pending-write flags
//   wr_cnt                      : saturating count of committed non-$0 writes
interface grf_wb_arbiter_if #(parameter int DW = 32, parameter int CW = 16);
  logic v0, v1, v2;
  logic [4:0] a0, a1, a2;
  logic [DW-1:0] d0, d1, d2;
  logic [DW-1:0] p0, p1, p2;
  logic rdy0, rdy1, rdy2;
  logic stall;
  logic WE;
  logic [4:0] A3;
  logic [DW-1:0] WD, pc;
  logic [4:0] ra1, ra2;
  logic pend1, pend2;
  logic [CW-1:0] wr_cnt;
  modport master (
    output v0, v1, v2, a0, a1, a2, d0, d1, d2, p0, p1, p2, stall, ra1, ra2,
    input rdy0, rdy1, rdy2, WE, A3, WD, pc, pend1, pend2, wr_cnt
  );
  modport slave (
    input v0, v1, v2, a0, a1, a2, d0, d1, d2, p0, p1, p2, stall, ra1, ra2,
    output rdy0, rdy1, rdy2, WE, A3, WD, pc, pend1, pend2, wr_cnt
  );
endinterface

// File: rtl/grf_wb_arbiter.sv
// grf_wb_arbiter: round-robin arbiter for the register file's single write port
//   clk   : clock, rising edge
//   reset : asynchronous active-low reset
//   b     : grf_wb_arbiter_if slave (source requests/grants, write port, hazard flags, counter)
module grf_wb_arbiter #(
  parameter int DW = 32,
  parameter int CW = 16
) (
  input logic clk,
  input logic reset,
  grf_wb_arbiter_if.slave b
);
  logic [2:0] vv;
  logic [1:0] ptr, o1, o2, win;
  logic go, we_n;
  logic [4:0] sa;
  logic [DW-1:0] sd, sp;
  logic we_q;
  logic [4:0] a3_q;
  logic [DW-1:0] wd_q, pc_q;
  logic [CW-1:0] cnt;
  always_comb begin
    vv = {b.v2, b.v1, b.v0};
    o1 = ptr == 2'd2 ? 2'd0 : ptr + 2'd1;
    o2 = ptr == 2'd0 ? 2'd2 : ptr - 2'd1;
    win = vv[ptr] ? ptr : vv[o1] ? o1 : o2;
    // grants are suppressed while reset is held so no request is consumed and lost
    go = reset && !b.stall && |vv;
    sa = win == 2'd0 ? b.a0 : win == 2'd1 ? b.a1 : b.a2;
    sd = win == 2'd0 ? b.d0 : win == 2'd1 ? b.d1 : b.d2;
    sp = win == 2'd0 ? b.p0 : win == 2'd1 ? b.p1 : b.p2;
    // a $0 write is consumed but never reaches the register file
    we_n = go && sa != 5'd0;
  end
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      we_q <= 1'b0;
      a3_q <= 5'd0;
      wd_q <= '0;
      pc_q <= '0;
      ptr <= 2'd0;
      cnt <= '0;
    end else begin
      we_q <= we_n;
      if (go) begin
        a3_q <= sa;
        wd_q <= sd;
        pc_q <= sp;
        ptr <= win == 2'd2 ? 2'd0 : win + 2'd1;
      end
      if (we_n && !(&cnt)) cnt <= cnt + 1'b1;
    end
  assign b.rdy0 = go && win == 2'd0;
  assign b.rdy1 = go && win == 2'd1;
  assign b.rdy2 = go && win == 2'd2;
  assign b.WE = we_q;
  assign b.A3 = a3_q;
  assign b.WD = wd_q;
  assign b.pc = pc_q;
  assign b.wr_cnt = cnt;
  // outstanding = still requesting, or sitting in the output stage this cycle
  assign b.pend1 = b.ra1 != 5'd0 && ((b.v0 && b.a0 == b.ra1) || (b.v1 && b.a1 == b.ra1) ||
                   (b.v2 && b.a2 == b.ra1) || (we_q && a3_q == b.ra1));
  assign b.pend2 = b.ra2 != 5'd0 && ((b.v0 && b.a0 == b.ra2) || (b.v1 && b.a1 == b.ra2) ||
                   (b.v2 && b.a2 == b.ra2) || (we_q && a3_q == b.ra2));
endmodule

// File: tb/tb_grf_wb_arbiter.sv
// tb_grf_wb_arbiter: directed-vector bench for grf_wb_arbiter
module tb_grf_wb_arbiter;
  logic clk = 1'b0;
  logic reset = 1'b0;
  int errs = 0;
  int n = 0;
  grf_wb_arbiter_if #(.DW(32), .CW(4)) bus ();
  grf_wb_arbiter #(.DW(32), .CW(4)) dut (.clk(clk), .reset(reset), .b(bus));
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  function automatic logic [2:0] rdy();
    return {bus.rdy2, bus.rdy1, bus.rdy0};
  endfunction
  initial begin
    bus.v0 = 1'b1; bus.v1 = 1'b0; bus.v2 = 1'b0;
    bus.a0 = 5'd5; bus.a1 = 5'd0; bus.a2 = 5'd0;
    bus.d0 = 32'h1234; bus.d1 = '0; bus.d2 = '0;
    bus.p0 = 32'h3000; bus.p1 = '0; bus.p2 = '0;
    bus.stall = 1'b0; bus.ra1 = 5'd0; bus.ra2 = 5'd0;
    #3;
    chk("rst_we", bus.WE, 0);
    chk("rst_a3", bus.A3, 0);
    chk("rst_wd", bus.WD, 0);
    chk("rst_pc", bus.pc, 0);
    chk("rst_cnt", bus.wr_cnt, 0);
    chk("rst_rdy", rdy(), 3'b000);
    #9 reset = 1'b1;
    #1;
    chk("first_rdy", rdy(), 3'b001);
    tick;
    bus.v0 = 1'b0;
    chk("first_we", bus.WE, 1);
    chk("first_a3", bus.A3, 5);
    chk("first_wd", bus.WD, 32'h1234);
    chk("first_pc", bus.pc, 32'h3000);
    chk("first_cnt", bus.wr_cnt, 1);
    bus.v2 = 1'b1; bus.a2 = 5'd3; bus.d2 = 32'h7;
    #1;
    chk("p1_rdy2", rdy(), 3'b100);
    tick;
    bus.v2 = 1'b0;
    chk("p1_cnt", bus.wr_cnt, 2);
    bus.v0 = 1'b1; bus.v1 = 1'b1; bus.v2 = 1'b1;
    bus.a0 = 5'd1; bus.a1 = 5'd2; bus.a2 = 5'd3;
    for (int k = 0; k < 6; k++) begin
      #1;
      chk("rr_rdy", rdy(), 3'b001 << (k % 3));
      tick;
      chk("rr_we", bus.WE, 1);
      chk("rr_a3", bus.A3, (k % 3) + 1);
    end
    bus.v0 = 1'b0; bus.v1 = 1'b0; bus.v2 = 1'b0;
    chk("rr_cnt", bus.wr_cnt, 8);
    bus.v1 = 1'b1; bus.a1 = 5'd0; bus.d1 = 32'hFFFF;
    #1;
    chk("z_rdy", rdy(), 3'b010);
    tick;
    bus.v1 = 1'b0;
    chk("z_we", bus.WE, 0);
    chk("z_cnt", bus.wr_cnt, 8);
    chk("z_wd", bus.WD, 32'hFFFF);
    bus.stall = 1'b1;
    bus.v2 = 1'b1; bus.a2 = 5'd9; bus.d2 = 32'h55;
    bus.v0 = 1'b1; bus.a0 = 5'd4;
    for (int k = 0; k < 3; k++) begin
      #1;
      chk("st_rdy", rdy(), 3'b000);
      tick;
      chk("st_we", bus.WE, 0);
    end
    chk("st_cnt", bus.wr_cnt, 8);
    bus.stall = 1'b0;
    #1;
    chk("st_rel_rdy", rdy(), 3'b100);
    tick;
    bus.v0 = 1'b0; bus.v2 = 1'b0;
    chk("st_rel_we", bus.WE, 1);
    chk("st_rel_a3", bus.A3, 9);
    chk("st_rel_wd", bus.WD, 32'h55);
    chk("st_rel_cnt", bus.wr_cnt, 9);
    tick;
    chk("idle_we", bus.WE, 0);
    bus.v0 = 1'b1; bus.a0 = 5'd8; bus.ra1 = 5'd8; bus.ra2 = 5'd0;
    bus.v1 = 1'b1; bus.a1 = 5'd0;
    #1;
    chk("pd_rdy", rdy(), 3'b001);
    chk("pd_p1", bus.pend1, 1);
    chk("pd_p2", bus.pend2, 0);
    tick;
    bus.v0 = 1'b0; bus.v1 = 1'b0;
    #1;
    chk("pd_we", bus.WE, 1);
    chk("pd_a3", bus.A3, 8);
    chk("pd_p1_we", bus.pend1, 1);
    tick;
    chk("pd_p1_drop", bus.pend1, 0);
    chk("pd_cnt", bus.wr_cnt, 10);
    bus.v0 = 1'b1; bus.a0 = 5'd12; bus.d0 = 32'hAB; bus.p0 = 32'hCD;
    tick;
    chk("mr_we", bus.WE, 1);
    #1 reset = 1'b0;
    #1;
    chk("mr_we0", bus.WE, 0);
    chk("mr_a3", bus.A3, 0);
    chk("mr_wd", bus.WD, 0);
    chk("mr_pc", bus.pc, 0);
    chk("mr_cnt", bus.wr_cnt, 0);
    chk("mr_rdy", rdy(), 3'b000);
    #3 reset = 1'b1;
    bus.v1 = 1'b1; bus.v2 = 1'b1; bus.a1 = 5'd2; bus.a2 = 5'd3;
    #1;
    chk("mr_ptr", rdy(), 3'b001);
    tick;
    bus.v1 = 1'b0; bus.v2 = 1'b0; bus.a0 = 5'd1;
    chk("mr_cnt1", bus.wr_cnt, 1);
    for (int k = 0; k < 20; k++) tick;
    chk("sat_cnt", bus.wr_cnt, 15);
    chk("sat_we", bus.WE, 1);
    bus.v0 = 1'b0;
    $display("Result: errors=%0d of %0d checks", errs, n);
    $finish;
  end
endmodule
